// File: rtl/hamming_enc74_tx.sv
// hamming_enc74_tx: byte-stream Hamming(7,4) encoder feeding the 7-bit
// syndrome decoder. Each accepted byte becomes two registered codewords,
// low nibble first. Codeword layout: parity in [2:0], data in [6:3].
//
// Optional feature: define ERR_INJ_EN to add inj_req/inj_pos, which flip one
// bit of a byte's low codeword so the decoder's correction path can be
// exercised. Without ERR_INJ_EN those ports are absent and codewords are clean.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no codeword pending; ready for a byte
// LO    | low-nibble codeword on c, waiting for c_ready
// HI    | high-nibble codeword on c; may accept the next byte on handoff
module hamming_enc74_tx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [6:0]       c,
    output logic             c_valid,
    input  logic             c_ready,
    output logic             c_last,
    output logic [CNT_W-1:0] cnt
`ifdef ERR_INJ_EN
    ,
    input  logic             inj_req,
    input  logic [2:0]       inj_pos
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hi_nib;
    logic [6:0] inj_mask;
    logic       accept;
    logic       load_hi;
    logic       c_hs;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] w;
        w[6:3] = n;
        w[0]   = n[0] ^ n[2] ^ n[3];
        w[1]   = n[0] ^ n[1] ^ n[2];
        w[2]   = n[1] ^ n[2] ^ n[3];
        return w;
    endfunction

    // Error-injection mask applied to the low codeword at byte acceptance.
    always_comb begin
        inj_mask = '0;
`ifdef ERR_INJ_EN
        if (inj_req && (inj_pos != 3'd7)) begin
            inj_mask = 7'b000_0001 << inj_pos;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (din_valid) state_nxt = LO;
            LO:   if (c_ready)   state_nxt = HI;
            HI:   if (c_ready)   state_nxt = din_valid ? LO : IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; din_ready is the only path from c_ready.
    always_comb begin
        c_valid   = (state != IDLE);
        din_ready = (state == IDLE) || ((state == HI) && c_ready);
    end

    assign accept  = din_valid && din_ready;
    assign load_hi = (state == LO) && c_ready;
    assign c_hs    = c_valid && c_ready;

    // Codeword datapath: loads only on byte acceptance or the low-codeword handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            c      <= '0;
            c_last <= 1'b0;
            hi_nib <= '0;
        end else if (accept) begin
            hi_nib <= din[7:4];
            c      <= enc(din[3:0]) ^ inj_mask;
            c_last <= 1'b0;
        end else if (load_hi) begin
            c      <= enc(hi_nib);
            c_last <= 1'b1;
        end
    end

    // Count of codewords handed off downstream; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (c_hs) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hamming_enc74_tx.sv
// Testbench for hamming_enc74_tx. Two instances share stimulus: CNT_W=16 and
// CNT_W=4 (counter wrap). Expected codewords are pushed to a scoreboard on
// byte acceptance and popped on each codeword handoff.
// Define ERR_INJ_EN to also cover the error-injection path.
module tb_hamming_enc74_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        c_ready;
    logic        din_ready, c_valid, c_last;
    logic [6:0]  c;
    logic [15:0] cnt;
    logic        din_ready4, c_valid4, c_last4;
    logic [6:0]  c4;
    logic [3:0]  cnt4;
`ifdef ERR_INJ_EN
    logic        inj_req;
    logic [2:0]  inj_pos;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [7:0] sb_q[$];   // {c_last, c}
    logic [6:0] b2b_c[4];

    always #5 clk = ~clk;

    hamming_enc74_tx #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .c(c), .c_valid(c_valid), .c_ready(c_ready),
        .c_last(c_last), .cnt(cnt)
`ifdef ERR_INJ_EN
        , .inj_req(inj_req), .inj_pos(inj_pos)
`endif
    );

    hamming_enc74_tx #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready4), .c(c4), .c_valid(c_valid4), .c_ready(c_ready),
        .c_last(c_last4), .cnt(cnt4)
`ifdef ERR_INJ_EN
        , .inj_req(inj_req), .inj_pos(inj_pos)
`endif
    );

    // Reference encoder written straight from the parity equations.
    function automatic logic [6:0] ref_enc(input logic [3:0] n);
        logic d3, d4, d5, d6;
        d3 = n[0]; d4 = n[1]; d5 = n[2]; d6 = n[3];
        return {d6, d5, d4, d3, d4 ^ d5 ^ d6, d3 ^ d4 ^ d5, d3 ^ d5 ^ d6};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: at the falling edge check counters and any handoff against
    // the scoreboard, record any byte acceptance, then return 1ns after the
    // rising edge so the caller can drive the next inputs.
    task automatic cycle();
        logic [7:0] e;
        logic [6:0] mask;
        @(negedge clk);
        if (rst) begin
            sb_q.delete();
            exp_cnt = 0;
        end else begin
            chk("cnt", {16'h0, cnt}, exp_cnt & 32'hFFFF);
            chk("cnt4", {28'h0, cnt4}, exp_cnt & 32'hF);
            if (c_valid && c_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_c", {25'h0, c}, {25'h0, e[6:0]});
                    chk("sb_c_last", {31'h0, c_last}, {31'h0, e[7]});
                    chk("sb_c4", {25'h0, c4}, {25'h0, e[6:0]});
                    chk("sb_c_last4", {31'h0, c_last4}, {31'h0, e[7]});
                end
                exp_cnt++;
            end
            if (din_valid && din_ready) begin
                mask = '0;
`ifdef ERR_INJ_EN
                if (inj_req && inj_pos != 3'd7) mask[inj_pos] = 1'b1;
`endif
                sb_q.push_back({1'b0, ref_enc(din[3:0]) ^ mask});
                sb_q.push_back({1'b1, ref_enc(din[7:4])});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        b2b_c[0] = 7'h00; b2b_c[1] = 7'h00; b2b_c[2] = 7'h7F; b2b_c[3] = 7'h7F;
        rst = 1'b1; din = 8'h00; din_valid = 1'b0; c_ready = 1'b0;
`ifdef ERR_INJ_EN
        inj_req = 1'b0; inj_pos = 3'd7;
`endif
        cycle();
        cycle();

        // Reset state, first din_ready right after release
        chk("rst_c_valid", {31'h0, c_valid}, 0);
        chk("rst_c", {25'h0, c}, 0);
        chk("rst_c_last", {31'h0, c_last}, 0);
        chk("rst_cnt", {16'h0, cnt}, 0);
        rst = 1'b0;
        chk("rel_din_ready", {31'h0, din_ready}, 1);

        // Single byte 0xA5 with c_ready high
        din = 8'hA5; din_valid = 1'b1; c_ready = 1'b1;
        cycle();
        din_valid = 1'b0;
        chk("a5_lo_c", {25'h0, c}, 32'h2C);
        chk("a5_lo_last", {31'h0, c_last}, 0);
        chk("a5_lo_valid", {31'h0, c_valid}, 1);
        chk("a5_lo_din_ready", {31'h0, din_ready}, 0);
        cycle();
        chk("a5_hi_c", {25'h0, c}, 32'h53);
        chk("a5_hi_last", {31'h0, c_last}, 1);
        chk("a5_hi_din_ready", {31'h0, din_ready}, 1);
        cycle();
        chk("a5_idle_valid", {31'h0, c_valid}, 0);
        chk("a5_cnt", {16'h0, cnt}, 2);

        // Back-to-back 0x00, 0xFF: no bubbles
        din = 8'h00; din_valid = 1'b1; c_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_din_ready", {31'h0, din_ready}, (i % 2 == 0) ? 1 : 0);
            cycle();
            if (i == 0) din = 8'hFF;
            if (i == 2) din_valid = 1'b0;
            chk("b2b_c", {25'h0, c}, {25'h0, b2b_c[i]});
            chk("b2b_valid", {31'h0, c_valid}, 1);
        end
        cycle();
        chk("b2b_idle_valid", {31'h0, c_valid}, 0);

        // Backpressure in LO for 5 cycles
        din = 8'hA5; din_valid = 1'b1; c_ready = 1'b0;
        cycle();
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_c", {25'h0, c}, 32'h2C);
            chk("bp_valid", {31'h0, c_valid}, 1);
            chk("bp_din_ready", {31'h0, din_ready}, 0);
            cycle();
        end
        c_ready = 1'b1;
        cycle();
        chk("bp_hi_c", {25'h0, c}, 32'h53);
        chk("bp_hi_last", {31'h0, c_last}, 1);
        cycle();

        // Reset while in HI, with a handoff and a new byte offered that cycle
        din = 8'h3C; din_valid = 1'b1; c_ready = 1'b1;
        cycle();
        din_valid = 1'b0;
        cycle();
        chk("pre_rst_last", {31'h0, c_last}, 1);
        rst = 1'b1; din = 8'hFF; din_valid = 1'b1;
        cycle();
        rst = 1'b0; din_valid = 1'b0;
        chk("hi_rst_valid", {31'h0, c_valid}, 0);
        chk("hi_rst_c", {25'h0, c}, 0);
        chk("hi_rst_last", {31'h0, c_last}, 0);
        chk("hi_rst_cnt", {16'h0, cnt}, 0);
        chk("hi_rst_cnt4", {28'h0, cnt4}, 0);
        chk("hi_rst_din_ready", {31'h0, din_ready}, 1);
        chk("hi_rst_din_ready4", {31'h0, din_ready4}, 1);
        chk("hi_rst_valid4", {31'h0, c_valid4}, 0);

        // Streaming 8 bytes: 16 handoffs, CNT_W=4 counter wraps 15 -> 0
        din = 8'($urandom); din_valid = 1'b1; c_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            cycle();
            if (k % 2 == 0) din = 8'($urandom);
            if (k == 14) din_valid = 1'b0;
            if (k == 15) chk("wrap_cnt4_15", {28'h0, cnt4}, 15);
            if (k == 16) begin
                chk("wrap_cnt4_0", {28'h0, cnt4}, 0);
                chk("wrap_cnt16", {16'h0, cnt}, 16);
            end
        end
        cycle();

`ifdef ERR_INJ_EN
        // Injection on bit 4 of the low codeword; high codeword untouched
        din = 8'hA5; din_valid = 1'b1; c_ready = 1'b0; inj_req = 1'b1; inj_pos = 3'd4;
        cycle();
        din_valid = 1'b0; inj_req = 1'b0;
        chk("inj_lo_c", {25'h0, c}, 32'h3C);
        c_ready = 1'b1;
        cycle();
        chk("inj_hi_c", {25'h0, c}, 32'h53);
        cycle();
        // inj_pos=7 disables the flip
        din = 8'hA5; din_valid = 1'b1; c_ready = 1'b0; inj_req = 1'b1; inj_pos = 3'd7;
        cycle();
        din_valid = 1'b0; inj_req = 1'b0;
        chk("inj7_lo_c", {25'h0, c}, 32'h2C);
        c_ready = 1'b1;
        cycle();
        cycle();
`endif

        cycle();
        chk("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_enc74_tx.md
# hamming_enc74_tx

Byte-stream Hamming(7,4) encoder, the stage directly upstream of the 7-bit syndrome decoder. Accepts bytes over a valid/ready handshake, splits each into two nibbles (low first) and emits one registered 7-bit codeword per nibble. Codeword bit layout matches the decoder exactly: parity in bits 2:0, data in bits 6:3. An optional error-injection path corrupts a chosen codeword bit so the decoder's single-bit correction can be exercised end to end.

## Interface
- CNT_W, 16, width of the emitted-codeword counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- din  input  8  byte to encode
- din_valid  input  1  din is valid
- din_ready  output  1  block accepts din this cycle
- c  output  7  codeword (registered)
- c_valid  output  1  c is valid
- c_ready  input  1  downstream accepts c this cycle
- c_last  output  1  c carries the high nibble of its byte
- cnt  output  CNT_W  codewords handed off since reset, wraps
- inj_req  input  1  inject an error into this byte's low codeword (ERR_INJ_EN only)
- inj_pos  input  3  bit to flip; 7 = no flip (ERR_INJ_EN only)

## Operation
- Data mapping per nibble n: c[3]=n[0], c[4]=n[1], c[5]=n[2], c[6]=n[3].
- Parity: c[0]=c3^c5^c6; c[1]=c3^c4^c5; c[2]=c4^c5^c6. A clean codeword yields zero syndrome at the decoder.
- FSM states:
  - IDLE: c_valid=0, din_ready=1. din_valid -> latch din[7:4] into the high-nibble register, load c=enc(din[3:0]), c_last=0, go LO.
  - LO: c_valid=1, c_last=0, din_ready=0. c_ready -> load c=enc(held high nibble), c_last=1, go HI.
  - HI: c_valid=1, c_last=1, din_ready=c_ready. c_ready & din_valid -> accept the new byte as in IDLE, go LO. c_ready & !din_valid -> c_valid=0, go IDLE.
- c, c_last and the held nibble change only on a load. With c_valid=1 and c_ready=0 all outputs hold; c_valid never drops without a handshake.
- cnt increments by 1 on every cycle with c_valid & c_ready; CNT_W-bit wrap from all-ones to 0.
- din_ready is combinational from state and c_ready; there is no other combinational in-to-out path.
- Reset (any state, mid-byte included): state IDLE, c=0, c_valid=0, c_last=0, cnt=0, held nibble=0. An in-flight byte is discarded. Reset overrides all handshakes in the same cycle.

## Timing
- Byte accepted on edge N -> low codeword valid after edge N; high codeword valid one cycle after the low codeword's handshake.
- With c_ready held high and din_valid continuous: one codeword per cycle, one byte every 2 cycles, no bubbles.
- Back-to-back boundary: in HI with c_ready=1 and din_valid=1, the high-codeword handoff and new-byte acceptance share one edge.
- First din_ready after reset release: the cycle following the last rst=1 cycle.

## Configuration
- ERR_INJ_EN defined: inj_req/inj_pos are sampled on byte acceptance. If inj_req=1 and inj_pos<7, the emitted low codeword has bit inj_pos inverted; the high codeword is never modified; inj_pos=7 disables the flip.
- ERR_INJ_EN undefined: inj_req and inj_pos are absent from the port list; codewords are always clean.

## Test plan
- Reset, then din=0xA5 with c_ready=1 -> c=0x2C (c_last=0), then c=0x53 (c_last=1); cnt=2; din_ready=1 the cycle after reset release.
- Bytes 0x00 and 0xFF back-to-back, c_ready=1 -> c sequence 0x00, 0x00, 0x7F, 0x7F on 4 consecutive cycles; din_ready high in cycles 0 and 2 only.
- din=0xA5, c_ready low for 5 cycles in LO -> c holds 0x2C, c_valid=1, din_ready=0 throughout; 0x53 follows after c_ready rises.
- rst asserted in HI -> next cycle c_valid=0, c=0, c_last=0, cnt=0, state IDLE.
- CNT_W=4: 16 codeword handshakes -> cnt goes 15 then 0.
- ERR_INJ_EN: din=0xA5, inj_req=1, inj_pos=4 -> low codeword 0x3C (decoder corrects to 0x2C); high codeword 0x53 unchanged; inj_pos=7 -> 0x2C.
